// File: rtl/led_s2p_rx_if.sv
// Serial LED link bundle: the four TX-driven pins plus the rebuilt parallel word and status.
// The master side drives the link; the receiver uses the slave side.
interface led_s2p_rx_if #(
    parameter int unsigned DATA_BITS       = 16,
    parameter int unsigned DATA_COUNT_BITS = 5
);
    logic                       led_clk;
    logic                       led_sout;
    logic                       led_clrn;
    logic                       LED_PEN;
    logic [DATA_BITS-1:0]       P_out;
    logic                       valid;
    logic                       frame_err;
    logic [DATA_COUNT_BITS-1:0] bit_cnt;

    modport master (
        output led_clk, led_sout, led_clrn, LED_PEN,
        input  P_out, valid, frame_err, bit_cnt
    );

    modport slave (
        input  led_clk, led_sout, led_clrn, LED_PEN,
        output P_out, valid, frame_err, bit_cnt
    );
endinterface

// File: rtl/led_s2p_rx.sv
// LED link receiver: rebuilds the parallel word from the serial shift chain using only
// system-clock logic (74HC595-style chain with a separate output latch).
module led_s2p_rx #(
    parameter int unsigned DATA_BITS       = 16,
    parameter int unsigned DATA_COUNT_BITS = 5,
    parameter bit          INVERT_REVERSE  = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    led_s2p_rx_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

    localparam logic [DATA_COUNT_BITS-1:0] FullCount = DATA_COUNT_BITS'(DATA_BITS);
    localparam logic [DATA_COUNT_BITS-1:0] OneCount  = DATA_COUNT_BITS'(1);

    logic [3:0]                 w_pins;
    logic [3:0]                 r_s1;
    logic [3:0]                 r_s2;
    logic [1:0]                 r_s3;
    logic                       w_clk_rise;
    logic                       w_pen_rise;
    logic                       w_sout;
    logic                       w_clrn;

    state_e                     r_state;
    state_e                     w_state_d;
    logic [DATA_BITS-1:0]       r_shreg;
    logic [DATA_BITS-1:0]       w_shreg_d;
    logic [DATA_BITS-1:0]       w_shifted;
    logic [DATA_COUNT_BITS-1:0] r_cnt;
    logic [DATA_COUNT_BITS-1:0] w_cnt_d;
    logic [DATA_COUNT_BITS-1:0] w_cnt_inc;
    logic [DATA_BITS-1:0]       w_decoded;
    logic [DATA_BITS-1:0]       r_p_out;
    logic                       r_valid;
    logic                       r_frame_err;

    assign w_pins = {bus.LED_PEN, bus.led_clrn, bus.led_sout, bus.led_clk};

    // Only led_clk and LED_PEN need the third stage; sout and clrn are used as levels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= w_pins;
            r_s2 <= r_s1;
            r_s3 <= {r_s2[3], r_s2[0]};
        end
    end

    assign w_clk_rise = r_s2[0] & ~r_s3[0];
    assign w_pen_rise = r_s2[3] & ~r_s3[1];
    assign w_sout     = r_s2[1];
    assign w_clrn     = r_s2[2];

    assign w_shifted = {r_shreg[DATA_BITS-2:0], w_sout};
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + OneCount;

    always_comb begin
        w_state_d = r_state;
        w_shreg_d = r_shreg;
        w_cnt_d   = r_cnt;
        if (!w_clrn) begin
            w_state_d = StIdle;
            w_shreg_d = '0;
            w_cnt_d   = '0;
        end else begin
            case (r_state)
                StIdle, StShift: begin
                    if (w_clk_rise) begin
                        w_shreg_d = w_shifted;
                        w_cnt_d   = w_cnt_inc;
                        w_state_d = StShift;
                    end
                    // A coincident shift lands in r_shreg before the latch reads it.
                    if (w_pen_rise) begin
                        w_state_d = StLatch;
                    end
                end
                StLatch: begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                    if (w_clk_rise) begin
                        w_shreg_d = w_shifted;
                        w_cnt_d   = OneCount;
                        w_state_d = StShift;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_shreg <= w_shreg_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_decoded = '0;
        for (int i = 0; i < int'(DATA_BITS); i++) begin
            w_decoded[i] = INVERT_REVERSE ? ~r_shreg[int'(DATA_BITS) - 1 - i] : r_shreg[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_p_out     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid <= (r_state == StLatch);
            if (r_state == StLatch) begin
                r_p_out <= w_decoded;
                if (r_cnt != FullCount) begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign bus.P_out     = r_p_out;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.bit_cnt   = r_cnt;

endmodule

// File: tb/tb_led_s2p_rx.sv
// Directed bench: one decoding and one raw receiver share the same serial stimulus;
// expected words are worked out by hand for each frame.
module tb_led_s2p_rx;

    logic clk = 1'b0;
    logic rstn;
    logic lclk, sout, clrn, pen;

    int checks = 0;
    int errors = 0;
    int vcnt_inv = 0, vcnt_raw = 0, dbl_valid = 0;
    logic prev_inv = 1'b0, prev_raw = 1'b0;
    int v0_inv, v0_raw;

    always #5 clk = ~clk;

    led_s2p_rx_if #(.DATA_BITS(16), .DATA_COUNT_BITS(5)) bus_inv ();
    led_s2p_rx_if #(.DATA_BITS(16), .DATA_COUNT_BITS(5)) bus_raw ();

    assign bus_inv.led_clk  = lclk;
    assign bus_inv.led_sout = sout;
    assign bus_inv.led_clrn = clrn;
    assign bus_inv.LED_PEN  = pen;
    assign bus_raw.led_clk  = lclk;
    assign bus_raw.led_sout = sout;
    assign bus_raw.led_clrn = clrn;
    assign bus_raw.LED_PEN  = pen;

    led_s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .INVERT_REVERSE(1'b1)) u_inv (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_inv)
    );

    led_s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .INVERT_REVERSE(1'b0)) u_raw (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_raw)
    );

    always @(negedge clk) begin
        if (bus_inv.valid) vcnt_inv++;
        if (bus_raw.valid) vcnt_raw++;
        if ((bus_inv.valid && prev_inv) || (bus_raw.valid && prev_raw)) dbl_valid++;
        prev_inv = bus_inv.valid;
        prev_raw = bus_raw.valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        sout = b;
        wait_clks(4);
        lclk = 1'b1;
        wait_clks(4);
        lclk = 1'b0;
    endtask

    // Raw order: MSB of the n-bit field goes first.
    task automatic shift_n(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    // Transmitter encoding: LED bit 0 first, inverted.
    task automatic tx_word(input logic [15:0] led);
        for (int i = 0; i < 16; i++) shift_bit(~led[i]);
    endtask

    task automatic pen_pulse();
        pen = 1'b1;
        wait_clks(4);
        pen = 1'b0;
        wait_clks(6);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        wait_clks(2);
        rstn = 1'b1;
        wait_clks(4);
    endtask

    initial begin
        rstn = 1'b0;
        lclk = 1'b0;
        sout = 1'b0;
        clrn = 1'b1;
        pen  = 1'b0;
        wait_clks(3);
        check("rst_pout", 32'(bus_inv.P_out), 32'h0);
        check("rst_valid", 32'(bus_inv.valid), 32'h0);
        check("rst_ferr", 32'(bus_inv.frame_err), 32'h0);
        check("rst_cnt", 32'(bus_inv.bit_cnt), 32'h0);
        rstn = 1'b1;
        wait_clks(4);

        // Reset in the middle of a frame.
        shift_n(16'h0055, 7);
        check("mid_cnt7", 32'(bus_inv.bit_cnt), 32'd7);
        rstn = 1'b0;
        wait_clks(2);
        check("midrst_pout", 32'(bus_inv.P_out), 32'h0);
        check("midrst_valid", 32'(bus_inv.valid), 32'h0);
        check("midrst_ferr", 32'(bus_inv.frame_err), 32'h0);
        check("midrst_cnt", 32'(bus_inv.bit_cnt), 32'h0);
        rstn = 1'b1;
        wait_clks(4);

        // Loopback of 16'h002A.
        v0_inv = vcnt_inv;
        tx_word(16'h002A);
        check("loop_cnt16", 32'(bus_inv.bit_cnt), 32'd16);
        pen_pulse();
        check("loop_pout", 32'(bus_inv.P_out), 32'h002A);
        check("loop_raw_pout", 32'(bus_raw.P_out), 32'hABFF);
        check("loop_valid1", 32'(vcnt_inv - v0_inv), 32'd1);
        check("loop_ferr", 32'(bus_inv.frame_err), 32'h0);
        check("loop_cnt0", 32'(bus_inv.bit_cnt), 32'h0);

        // Raw 1 followed by fifteen 0s.
        shift_n(16'h8000, 16);
        pen_pulse();
        check("raw_pout", 32'(bus_raw.P_out), 32'h8000);
        check("raw_inv_pout", 32'(bus_inv.P_out), 32'hFFFE);
        check("raw_ferr", 32'(bus_raw.frame_err), 32'h0);

        // Chain clear after 5 bits, then a full A5A5 frame.
        shift_n(16'h001F, 5);
        clrn = 1'b0;
        wait_clks(4);
        check("clr_cnt", 32'(bus_raw.bit_cnt), 32'h0);
        clrn = 1'b1;
        wait_clks(4);
        shift_n(16'hA5A5, 16);
        pen_pulse();
        check("clr_raw_pout", 32'(bus_raw.P_out), 32'hA5A5);
        check("clr_inv_pout", 32'(bus_inv.P_out), 32'h5A5A);
        check("clr_ferr", 32'(bus_raw.frame_err), 32'h0);

        // Bit 16 rises together with PEN.
        v0_raw = vcnt_raw;
        shift_n(16'h091A, 15);
        sout = 1'b0;
        wait_clks(4);
        lclk = 1'b1;
        pen  = 1'b1;
        wait_clks(4);
        lclk = 1'b0;
        pen  = 1'b0;
        wait_clks(6);
        check("sim_raw_pout", 32'(bus_raw.P_out), 32'h1234);
        check("sim_inv_pout", 32'(bus_inv.P_out), 32'hD3B7);
        check("sim_ferr", 32'(bus_raw.frame_err), 32'h0);
        check("sim_valid1", 32'(vcnt_raw - v0_raw), 32'd1);
        check("sim_cnt0", 32'(bus_raw.bit_cnt), 32'h0);

        // Overlong frame: 20 bits, last 16 are 0F0F.
        shift_n(16'h000F, 4);
        shift_n(16'h0F0F, 16);
        check("long_cnt20", 32'(bus_raw.bit_cnt), 32'd20);
        pen_pulse();
        check("long_raw_pout", 32'(bus_raw.P_out), 32'h0F0F);
        check("long_ferr", 32'(bus_raw.frame_err), 32'h1);

        // PEN with an empty chain still latches and flags the frame.
        do_reset();
        v0_inv = vcnt_inv;
        pen_pulse();
        check("idle_raw_pout", 32'(bus_raw.P_out), 32'h0);
        check("idle_inv_pout", 32'(bus_inv.P_out), 32'hFFFF);
        check("idle_valid1", 32'(vcnt_inv - v0_inv), 32'd1);
        check("idle_ferr", 32'(bus_inv.frame_err), 32'h1);

        // Short frame, then a good frame: error stays set.
        do_reset();
        check("short_ferr_pre", 32'(bus_inv.frame_err), 32'h0);
        v0_inv = vcnt_inv;
        shift_n(16'h0ABC, 12);
        pen_pulse();
        check("short_valid1", 32'(vcnt_inv - v0_inv), 32'd1);
        check("short_raw_pout", 32'(bus_raw.P_out), 32'h0ABC);
        check("short_ferr", 32'(bus_inv.frame_err), 32'h1);
        tx_word(16'h1357);
        pen_pulse();
        check("sticky_pout", 32'(bus_inv.P_out), 32'h1357);
        check("sticky_ferr", 32'(bus_inv.frame_err), 32'h1);

        // Counter saturates at all-ones.
        for (int i = 0; i < 33; i++) shift_bit(1'b1);
        check("sat_cnt", 32'(bus_inv.bit_cnt), 32'd31);
        clrn = 1'b0;
        wait_clks(4);
        clrn = 1'b1;
        wait_clks(4);
        check("sat_clr_cnt", 32'(bus_inv.bit_cnt), 32'h0);

        check("no_double_valid", 32'(dbl_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
